// File: rtl/cache_instruction_issue.sv
// Issue stage ahead of the cache load/store pipeline: op FIFO, RAW hazard hold-back, registered bundle.
// Optional CACHE_ISSUE_STATS_EN adds saturating issue/hazard-stall counters.
module cache_instruction_issue #(
  parameter int DEPTH        = 4,
  parameter int HAZARD_DEPTH = 2,
  parameter int SLOT_W       = 2,
  parameter int ADDR_W       = 11,
  parameter int REG_W        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic [SLOT_W-1:0] in_cache_slot,
  input  logic [ADDR_W-1:0] in_cache_addr,
  input  logic [REG_W-1:0]  in_regfile_reg,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid,
  output logic              out_is_load,
  output logic [SLOT_W-1:0] out_cache_slot,
  output logic [ADDR_W-1:0] out_cache_addr,
  output logic [REG_W-1:0]  out_regfile_reg
`ifdef CACHE_ISSUE_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_hazard_stalls
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic              is_load;
    logic [SLOT_W-1:0] slot;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  rg;
  } op_t;

  typedef struct packed {
    logic valid;
    op_t  op;
  } hist_t;

  op_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  hist_t      hist_q [HAZARD_DEPTH];
  hist_t      hist_d [HAZARD_DEPTH];
  logic       out_valid_q, out_valid_d;
  op_t        out_q, out_d, head, in_op;
  logic       empty, full, push, issue, hazard;

  assign in_op  = '{is_load: in_is_load, slot: in_cache_slot, addr: in_cache_addr, rg: in_regfile_reg};
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign head   = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign in_ready = !full;
  // A push offered in a flush cycle is dropped along with the queue contents.
  assign push   = in_valid && !full && !flush_i;
  assign issue  = !empty && !stall_i && !flush_i && !hazard;

  // Stores read the regfile (RAW against in-flight loads); loads read the cache (RAW against in-flight stores).
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (hist_q[i].valid) begin
        if (!head.is_load && hist_q[i].op.is_load && (hist_q[i].op.rg == head.rg))
          hazard = 1'b1;
        if (head.is_load && !hist_q[i].op.is_load &&
            ({hist_q[i].op.slot, hist_q[i].op.addr} == {head.slot, head.addr}))
          hazard = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d    = flush_i ? wr_ptr_q : rd_ptr_q + (issue ? PTR_W'(1) : PTR_W'(0));
    out_valid_d = issue;
    out_d       = issue ? head : out_q;
    hist_d[0]   = '{valid: issue, op: head};
    for (int i = 1; i < HAZARD_DEPTH; i++)
      hist_d[i] = hist_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q[IDX_W-1:0]] <= in_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int i = 0; i < HAZARD_DEPTH; i++)
        hist_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      for (int i = 0; i < HAZARD_DEPTH; i++)
        hist_q[i] <= hist_d[i];
    end
  end

  assign out_valid       = out_valid_q;
  assign out_is_load     = out_q.is_load;
  assign out_cache_slot  = out_q.slot;
  assign out_cache_addr  = out_q.addr;
  assign out_regfile_reg = out_q.rg;

`ifdef CACHE_ISSUE_STATS_EN
  logic [15:0] issued_q, hz_q;
  logic        hz_stall;

  assign hz_stall = !empty && !stall_i && !flush_i && hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      hz_q     <= '0;
    end else begin
      if (issue && (issued_q != 16'hFFFF))
        issued_q <= issued_q + 16'd1;
      if (hz_stall && (hz_q != 16'hFFFF))
        hz_q <= hz_q + 16'd1;
    end
  end

  assign stat_issued        = issued_q;
  assign stat_hazard_stalls = hz_q;
`endif

endmodule
